// File: rtl/astro_pkg.sv
// Shared game-state encoding and default widths for the shooter display.
// The state values feed the status LEDs directly, so the encoding is fixed.
package astro_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_GAME_1 = 2'b01,
      ST_GAME_2 = 2'b10,
      ST_DONE   = 2'b11
   } gameState_t;

   localparam int SCORE_W_DEF = 4;

endpackage

// File: rtl/game_sequencer_sat_accum.sv
// Saturating accumulator register used for the score.
// Clear has priority over add; the sum sticks at all-ones instead of wrapping.
module sat_accum #(
   parameter int W     = 4,
   parameter int INC_W = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             addEn,
   input  logic [INC_W-1:0] incr,
   output logic [W-1:0]     value
);

   localparam int SW = ((W > INC_W) ? W : INC_W) + 1;
   localparam logic [SW-1:0] MAX_EXT = SW'({W{1'b1}});

   logic [SW-1:0] sum;

   always_comb begin
      sum = SW'(value) + SW'(incr);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         value <= '0;
      end else if (clear) begin
         value <= '0;
      end else if (addEn) begin
         value <= (sum > MAX_EXT) ? {W{1'b1}} : sum[W-1:0];
      end
   end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: IDLE -> GAME_1 -> GAME_2 -> DONE, shot budget, alive mask, score.
// Define GAME_SEQ_BONUS_EN to add leftover shots to the score on each level clear.
module game_sequencer
   import astro_pkg::*;
#(
   parameter int NUM_TARGETS     = 2,
   parameter int SHOTS_PER_LEVEL = 8,
   parameter int SCORE_W         = SCORE_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   tick,
   input  logic                   start,
   input  logic                   fire_req,
   input  logic [NUM_TARGETS-1:0] hit,
   input  logic                   bullet_done,
   output logic [1:0]             state,
   output logic                   shoot_grant,
   output logic                   in_flight,
   output logic [NUM_TARGETS-1:0] target_alive,
   output logic                   reload,
   output logic [3:0]             shots_left,
   output logic [SCORE_W-1:0]     score,
   output logic                   win
);

   localparam int INC_W = $clog2(NUM_TARGETS + 16) + 1;
   localparam logic [3:0] SHOTS_INIT = 4'(SHOTS_PER_LEVEL);
   localparam logic [NUM_TARGETS-1:0] ALL_ALIVE = '1;

   gameState_t             curState, nextState;
   logic                   nextGrant, nextFlight, nextReload, nextWin;
   logic [NUM_TARGETS-1:0] nextAlive, hitLive;
   logic [3:0]             nextShots;
   logic                   scoreClear, scoreAdd;
   logic [INC_W-1:0]       scoreInc;

   assign state = curState;

   // Decisions are taken only on tick cycles; the pulse outputs default back to 0 otherwise.
   // Within a game tick the hit/bullet_done/fire priority is resolved first, and the
   // level-clear / out-of-shots checks then look at the resulting mask and budget.
   always_comb begin
      nextState  = curState;
      nextGrant  = 1'b0;
      nextReload = 1'b0;
      nextFlight = in_flight;
      nextAlive  = target_alive;
      nextShots  = shots_left;
      nextWin    = win;
      scoreClear = 1'b0;
      scoreAdd   = 1'b0;
      scoreInc   = '0;
      hitLive    = hit & target_alive;

      if (tick) begin
         case (curState)
            ST_IDLE: begin
               if (start) begin
                  nextState  = ST_GAME_1;
                  scoreClear = 1'b1;
                  nextWin    = 1'b0;
                  nextShots  = SHOTS_INIT;
                  nextAlive  = ALL_ALIVE;
                  nextReload = 1'b1;
                  nextFlight = 1'b0;
               end
            end
            ST_GAME_1, ST_GAME_2: begin
               if (in_flight && (|hit)) begin
                  nextAlive  = target_alive & ~hit;
                  nextFlight = 1'b0;
                  scoreAdd   = 1'b1;
                  for (int i = 0; i < NUM_TARGETS; i++) begin
                     scoreInc = scoreInc + INC_W'(hitLive[i]);
                  end
               end else if (in_flight && bullet_done) begin
                  nextFlight = 1'b0;
               end else if (!in_flight && fire_req && (shots_left != 4'd0)) begin
                  nextGrant  = 1'b1;
                  nextFlight = 1'b1;
                  nextShots  = shots_left - 4'd1;
               end

               // The bonus must see the budget before GAME_1 reloads it.
               if (nextAlive == '0) begin
`ifdef GAME_SEQ_BONUS_EN
                  scoreAdd = 1'b1;
                  scoreInc = scoreInc + INC_W'(nextShots);
`endif
                  if (curState == ST_GAME_1) begin
                     nextState  = ST_GAME_2;
                     nextReload = 1'b1;
                     nextAlive  = ALL_ALIVE;
                     nextShots  = SHOTS_INIT;
                     nextFlight = 1'b0;
                  end else begin
                     nextState = ST_DONE;
                     nextWin   = 1'b1;
                  end
               end else if ((nextShots == 4'd0) && !nextFlight) begin
                  nextState = ST_DONE;
                  nextWin   = 1'b0;
               end
            end
            ST_DONE: begin
               if (!start) begin
                  nextState = ST_IDLE;
               end
            end
            default: begin
               nextState = ST_IDLE;
            end
         endcase
      end
   end

   // Registered outputs; reset wins over any pending game decision.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         curState     <= ST_IDLE;
         shoot_grant  <= 1'b0;
         in_flight    <= 1'b0;
         target_alive <= ALL_ALIVE;
         reload       <= 1'b0;
         shots_left   <= 4'd0;
         win          <= 1'b0;
      end else begin
         curState     <= nextState;
         shoot_grant  <= nextGrant;
         in_flight    <= nextFlight;
         target_alive <= nextAlive;
         reload       <= nextReload;
         shots_left   <= nextShots;
         win          <= nextWin;
      end
   end

   sat_accum #(
      .W     (SCORE_W),
      .INC_W (INC_W)
   ) scoreAcc (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (scoreClear),
      .addEn   (scoreAdd),
      .incr    (scoreInc),
      .value   (score)
   );

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: each scenario queues expected outputs per cycle
// and compares them against the DUT one clock after the stimulus is applied.
module tb_game_sequencer;

   typedef struct packed {
      logic [1:0] st;
      logic       grant;
      logic       fl;
      logic [1:0] alive;
      logic       rel;
      logic [3:0] shots;
      logic [3:0] score;
      logic       win;
   } outs_t;

   typedef struct packed {
      logic       rstn;
      logic       tk;
      logic       startV;
      logic       fire;
      logic [1:0] hitV;
      logic       bd;
   } stim_t;

`ifdef GAME_SEQ_BONUS_EN
   localparam logic [3:0] SC_L1  = 4'd7;
   localparam logic [3:0] SC_END = 4'd15;
   localparam logic [3:0] SC_MID = 4'd9;
`else
   localparam logic [3:0] SC_L1  = 4'd2;
   localparam logic [3:0] SC_END = 4'd4;
   localparam logic [3:0] SC_MID = 4'd2;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick = 1'b0;
   logic       start = 1'b0;
   logic       fire_req = 1'b0;
   logic [1:0] hit = 2'b00;
   logic       bullet_done = 1'b0;
   logic [1:0] state;
   logic       shoot_grant;
   logic       in_flight;
   logic [1:0] target_alive;
   logic       reload;
   logic [3:0] shots_left;
   logic [3:0] score;
   logic       win;

   int    checks = 0;
   int    errors = 0;
   outs_t expQ[$];

   always #5 clk = ~clk;

   game_sequencer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .tick         (tick),
      .start        (start),
      .fire_req     (fire_req),
      .hit          (hit),
      .bullet_done  (bullet_done),
      .state        (state),
      .shoot_grant  (shoot_grant),
      .in_flight    (in_flight),
      .target_alive (target_alive),
      .reload       (reload),
      .shots_left   (shots_left),
      .score        (score),
      .win          (win)
   );

   function automatic outs_t mk(input logic [1:0] st, input logic g, input logic fl,
                                input logic [1:0] al, input logic rel, input logic [3:0] sh,
                                input logic [3:0] sc, input logic w);
      outs_t o;
      o = '{st, g, fl, al, rel, sh, sc, w};
      return o;
   endfunction

   function automatic stim_t S(input logic r, input logic t, input logic s, input logic f,
                               input logic [1:0] h, input logic b);
      stim_t x;
      x = '{r, t, s, f, h, b};
      return x;
   endfunction

   function automatic outs_t snap();
      outs_t o;
      o = '{state, shoot_grant, in_flight, target_alive, reload, shots_left, score, win};
      return o;
   endfunction

   task automatic applyStimulus(input stim_t s);
      reset_n     = s.rstn;
      tick        = s.tk;
      start       = s.startV;
      fire_req    = s.fire;
      hit         = s.hitV;
      bullet_done = s.bd;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      stim_t sq[$];
      outs_t obs, exp;
      sq.push_back(S(0,0,0,0,2'b00,0)); expQ.push_back(mk(2'b00,0,0,2'b11,0,0,0,0));
      sq.push_back(S(0,1,1,1,2'b11,1)); expQ.push_back(mk(2'b00,0,0,2'b11,0,0,0,0));
      sq.push_back(S(1,0,1,0,2'b00,0)); expQ.push_back(mk(2'b00,0,0,2'b11,0,0,0,0));
      foreach (sq[i]) begin
         applyStimulus(sq[i]);
         obs = snap();
         exp = expQ.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL test_reset step %0d: got %p want %p", i, obs, exp);
         end
      end
   endtask

   task automatic test_start();
      stim_t sq[$];
      outs_t obs, exp;
      sq.push_back(S(1,1,1,0,2'b00,0)); expQ.push_back(mk(2'b01,0,0,2'b11,1,8,0,0));
      sq.push_back(S(1,0,1,0,2'b00,0)); expQ.push_back(mk(2'b01,0,0,2'b11,0,8,0,0));
      sq.push_back(S(1,1,0,0,2'b00,0)); expQ.push_back(mk(2'b01,0,0,2'b11,0,8,0,0));
      foreach (sq[i]) begin
         applyStimulus(sq[i]);
         obs = snap();
         exp = expQ.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL test_start step %0d: got %p want %p", i, obs, exp);
         end
      end
   endtask

   task automatic test_fire_hold();
      stim_t sq[$];
      outs_t obs, exp;
      sq.push_back(S(1,1,0,1,2'b00,0)); expQ.push_back(mk(2'b01,1,1,2'b11,0,7,0,0));
      for (int k = 0; k < 4; k++) begin
         sq.push_back(S(1,1,0,1,2'b00,0)); expQ.push_back(mk(2'b01,0,1,2'b11,0,7,0,0));
      end
      sq.push_back(S(1,0,0,1,2'b01,0)); expQ.push_back(mk(2'b01,0,1,2'b11,0,7,0,0));
      sq.push_back(S(1,1,0,1,2'b00,1)); expQ.push_back(mk(2'b01,0,0,2'b11,0,7,0,0));
      sq.push_back(S(1,1,0,1,2'b00,0)); expQ.push_back(mk(2'b01,1,1,2'b11,0,6,0,0));
      sq.push_back(S(1,1,0,0,2'b00,1)); expQ.push_back(mk(2'b01,0,0,2'b11,0,6,0,0));
      foreach (sq[i]) begin
         applyStimulus(sq[i]);
         obs = snap();
         exp = expQ.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL test_fire_hold step %0d: got %p want %p", i, obs, exp);
         end
      end
   endtask

   task automatic test_level_clear();
      stim_t sq[$];
      outs_t obs, exp;
      sq.push_back(S(0,0,0,0,2'b00,0)); expQ.push_back(mk(2'b00,0,0,2'b11,0,0,0,0));
      sq.push_back(S(1,1,1,0,2'b00,0)); expQ.push_back(mk(2'b01,0,0,2'b11,1,8,0,0));
      sq.push_back(S(1,1,0,1,2'b00,0)); expQ.push_back(mk(2'b01,1,1,2'b11,0,7,0,0));
      sq.push_back(S(1,1,0,0,2'b01,0)); expQ.push_back(mk(2'b01,0,0,2'b10,0,7,1,0));
      sq.push_back(S(1,1,0,1,2'b00,0)); expQ.push_back(mk(2'b01,1,1,2'b10,0,6,1,0));
      sq.push_back(S(1,1,0,0,2'b01,0)); expQ.push_back(mk(2'b01,0,0,2'b10,0,6,1,0));
      sq.push_back(S(1,1,0,1,2'b00,0)); expQ.push_back(mk(2'b01,1,1,2'b10,0,5,1,0));
      sq.push_back(S(1,1,0,0,2'b10,0)); expQ.push_back(mk(2'b10,0,0,2'b11,1,8,SC_L1,0));
      sq.push_back(S(1,0,0,0,2'b00,0)); expQ.push_back(mk(2'b10,0,0,2'b11,0,8,SC_L1,0));
      foreach (sq[i]) begin
         applyStimulus(sq[i]);
         obs = snap();
         exp = expQ.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL test_level_clear step %0d: got %p want %p", i, obs, exp);
         end
      end
   endtask

   task automatic test_simultaneous();
      stim_t sq[$];
      outs_t obs, exp;
      sq.push_back(S(1,1,0,0,2'b11,0)); expQ.push_back(mk(2'b10,0,0,2'b11,0,8,SC_L1,0));
      sq.push_back(S(1,1,0,1,2'b00,0)); expQ.push_back(mk(2'b10,1,1,2'b11,0,7,SC_L1,0));
      sq.push_back(S(1,1,0,0,2'b11,1)); expQ.push_back(mk(2'b11,0,0,2'b00,0,7,SC_END,1));
      sq.push_back(S(1,1,1,1,2'b00,0)); expQ.push_back(mk(2'b11,0,0,2'b00,0,7,SC_END,1));
      sq.push_back(S(1,1,0,0,2'b00,0)); expQ.push_back(mk(2'b00,0,0,2'b00,0,7,SC_END,1));
      sq.push_back(S(1,1,1,0,2'b00,0)); expQ.push_back(mk(2'b01,0,0,2'b11,1,8,0,0));
      foreach (sq[i]) begin
         applyStimulus(sq[i]);
         obs = snap();
         exp = expQ.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL test_simultaneous step %0d: got %p want %p", i, obs, exp);
         end
      end
   endtask

   task automatic test_out_of_shots();
      stim_t sq[$];
      outs_t obs, exp;
      for (int k = 1; k <= 8; k++) begin
         sq.push_back(S(1,1,0,1,2'b00,0));
         expQ.push_back(mk(2'b01,1,1,2'b11,0,4'(8-k),0,0));
         sq.push_back(S(1,1,0,0,2'b00,1));
         if (k < 8) expQ.push_back(mk(2'b01,0,0,2'b11,0,4'(8-k),0,0));
         else       expQ.push_back(mk(2'b11,0,0,2'b11,0,0,0,0));
      end
      sq.push_back(S(1,1,1,1,2'b00,0)); expQ.push_back(mk(2'b11,0,0,2'b11,0,0,0,0));
      sq.push_back(S(1,1,0,0,2'b00,0)); expQ.push_back(mk(2'b00,0,0,2'b11,0,0,0,0));
      foreach (sq[i]) begin
         applyStimulus(sq[i]);
         obs = snap();
         exp = expQ.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL test_out_of_shots step %0d: got %p want %p", i, obs, exp);
         end
      end
   endtask

   task automatic test_reset_midgame();
      stim_t sq[$];
      outs_t obs, exp;
      sq.push_back(S(1,1,1,0,2'b00,0)); expQ.push_back(mk(2'b01,0,0,2'b11,1,8,0,0));
      sq.push_back(S(1,1,0,1,2'b00,0)); expQ.push_back(mk(2'b01,1,1,2'b11,0,7,0,0));
      sq.push_back(S(1,1,0,0,2'b11,0)); expQ.push_back(mk(2'b10,0,0,2'b11,1,8,SC_MID,0));
      sq.push_back(S(1,1,0,1,2'b00,0)); expQ.push_back(mk(2'b10,1,1,2'b11,0,7,SC_MID,0));
      sq.push_back(S(0,1,1,1,2'b00,0)); expQ.push_back(mk(2'b00,0,0,2'b11,0,0,0,0));
      sq.push_back(S(1,0,0,0,2'b00,0)); expQ.push_back(mk(2'b00,0,0,2'b11,0,0,0,0));
      foreach (sq[i]) begin
         applyStimulus(sq[i]);
         obs = snap();
         exp = expQ.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL test_reset_midgame step %0d: got %p want %p", i, obs, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_fire_hold();
      test_level_clear();
      test_simultaneous();
      test_out_of_shots();
      test_reset_midgame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Game-flow controller for the shooter display. It sequences the play states IDLE → GAME_1 → GAME_2 → DONE and grants bullet launches against a per-level shot budget. It tracks which targets are still alive, keeps the score and tells the target/bullet datapath when to reload. It sits between the button/switch inputs and the motion/drawing logic, and its state encoding drives the status LEDs directly.

## Interface
Parameters:
- NUM_TARGETS, 2: number of targets per level; one hit bit each.
- SHOTS_PER_LEVEL, 8: shot budget loaded at each level start; 1..15.
- SCORE_W, 4: score width; score saturates at 2^SCORE_W-1.

Ports (synchronous, active-low reset; all registers in the clk domain):
- clk, input, 1: system clock.
- reset_n, input, 1: synchronous active-low reset.
- tick, input, 1: one-cycle game-tick strobe; all game decisions are qualified by it.
- start, input, 1: start switch level.
- fire_req, input, 1: fire button level.
- hit, input, NUM_TARGETS: one-cycle pulses, bit i = bullet overlapped target i.
- bullet_done, input, 1: one-cycle pulse, bullet left the screen.
- state, output, 2: IDLE=00, GAME_1=01, GAME_2=10, DONE=11.
- shoot_grant, output, 1: one-cycle pulse that launches a bullet from the ship.
- in_flight, output, 1: a bullet is active.
- target_alive, output, NUM_TARGETS: target i is still drawn and moving.
- reload, output, 1: one-cycle pulse telling the datapath to restore target positions.
- shots_left, output, 4: remaining shot budget.
- score, output, SCORE_W: accumulated hits.
- win, output, 1: DONE was reached by clearing GAME_2.

## Operation
- Reset (reset_n=0 at a clk edge): the block goes to the following values regardless of current state or an in-flight bullet.
  - state=IDLE, shoot_grant=0, in_flight=0.
  - target_alive=all 1s, reload=0, shots_left=0, score=0, win=0.
- IDLE: on a tick with start=1, go to GAME_1.
  - Same cycle: score←0, win←0, shots_left←SHOTS_PER_LEVEL, target_alive←all 1s, reload pulses.
- GAME_1 / GAME_2, evaluated only on tick cycles, in this priority order:
  1. Hit: if in_flight=1 and hit has any bit set:
     - target_alive &= ~hit; score += popcount(hit & target_alive), saturating; in_flight←0.
     - Hits on dead targets add nothing.
     - Hits with in_flight=0 are ignored entirely.
  2. Bullet done: else if in_flight=1 and bullet_done=1, then in_flight←0. hit and bullet_done together count as a hit only.
  3. Fire: else if in_flight=0 and fire_req=1 and shots_left>0, then shoot_grant=1, in_flight←1, shots_left−1. A held button re-fires only after in_flight clears.
  4. Level clear: if the resulting target_alive is all 0s:
     - GAME_1: go to GAME_2 with reload pulse, target_alive←all 1s, shots_left←SHOTS_PER_LEVEL, in_flight←0.
     - GAME_2: go to DONE with win←1.
  5. Out of shots: else if the resulting shots_left=0 and in_flight=0, go to DONE with win=0.
- DONE: outputs hold. On a tick with start=0, go to IDLE; score and win stay held until the next game start.
- start=0 during GAME_x has no effect.
- Non-tick cycles: nothing changes except that shoot_grant and reload return to 0.

## Timing
- All outputs are registered. shoot_grant and reload are asserted for exactly the one clk cycle following the deciding tick edge.
- Latency from a tick carrying a qualifying event to the updated outputs is 1 clk.
- Every hit or bullet_done pulse must coincide with a tick. Pulses on non-tick cycles are dropped; this is a documented requirement on the datapath.
- shots_left never wraps below 0. score never wraps above its maximum.

## Configuration
- GAME_SEQ_BONUS_EN defined: on a level clear, the leftover shots_left (after that tick's update) is added to score in the same update, saturating.
- GAME_SEQ_BONUS_EN undefined: no bonus; score counts hits only.

## Structure
- Shared package astro_pkg holds:
  - the state encoding constants ST_IDLE, ST_GAME_1, ST_GAME_2, ST_DONE (reused by the LED logic);
  - SCORE_W_DEF.
- One sub-module, sat_accum: a parameterized saturating adder/register for score, with clear, add-enable and an increment input.
- The main FSM, shot counter and alive mask stay in game_sequencer.

## Test plan
Each scenario uses the default parameters.
1. Reset, then tick with start=1 → state=01, shots_left=8, target_alive=11, score=0, one reload pulse.
2. fire_req held for 5 ticks with no hit or bullet_done → exactly one shoot_grant pulse, shots_left=7, in_flight=1. Then bullet_done → in_flight=0, and the next tick grants again (shots_left=6).
3. Fire then hit=01, fire then hit=01 again, fire then hit=10 → score=2, target_alive=00, state=10, shots_left=8, reload pulse.
   - With GAME_SEQ_BONUS_EN: score=2+5=7.
4. hit=11 and bullet_done together while in_flight → score+2, one in_flight clear, level clears. A hit pulse with in_flight=0 leaves score unchanged.
5. Fire 8 shots, each ending in bullet_done → after the 8th bullet_done, state=11, win=0, shots_left=0. Then a tick with start=0 → state=00, with score held.
6. reset_n=0 during GAME_2 with a bullet in flight → next cycle state=00, in_flight=0, score=0, target_alive=11, with no grant or reload pulse.
